// File: rtl/demux_lane_buf_pkg.sv
// rtl/demux_lane_buf_pkg.sv - shared constants, select-width helper and lane index type for demux_lane_buf
package demux_lane_buf_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;
    localparam int MAX_LANES = 16;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef logic [sel_width(MAX_LANES)-1:0] lane_idx_t;

endpackage

// File: rtl/demux_lane_slot.sv
// rtl/demux_lane_slot.sv - one-entry valid/ready output buffer for a single demux lane
module demux_lane_slot
    import demux_lane_buf_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         can_accept
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // A drain and a write in the same cycle keep the slot full, giving one word per cycle.
    assign can_accept = !valid_q || rd_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && rd_ready) begin
            valid_d = 1'b0;
        end
        if (wr_en) begin
            valid_d = 1'b1;
            data_d  = wr_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/demux_lane_buf.sv
// rtl/demux_lane_buf.sv - registered 1-to-N demultiplexer with per-lane one-entry buffers
module demux_lane_buf
    import demux_lane_buf_pkg::*;
#(
    parameter int N_OUT   = 2,
    parameter int W       = 1,
    parameter int MODE_RR = 0,
    localparam int SW     = sel_width(N_OUT)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [W-1:0]       I,
    input  logic               I_VALID,
    output logic               I_READY,
    input  logic [SW-1:0]      S,
    output logic [N_OUT*W-1:0] O,
    output logic [N_OUT-1:0]   O_VALID,
    input  logic [N_OUT-1:0]   O_READY,
    output logic [SW-1:0]      PTR
);

    localparam int LANES = 1 << SW;

    logic [SW-1:0]    ptr_q, ptr_d;
    logic [SW-1:0]    tgt;
    logic             tgt_ok;
    logic             accept;
    logic [N_OUT-1:0] can_acc;
    logic [N_OUT-1:0] wr_en;
    logic [LANES-1:0] lane_rdy;

    assign tgt    = (MODE_RR != MODE_SEL) ? ptr_q : S;
    assign tgt_ok = ({1'b0, tgt} < (SW+1)'(N_OUT));

    // Pad to a power of two so an out-of-range target reads a defined 0.
    always_comb begin
        lane_rdy              = '0;
        lane_rdy[N_OUT-1:0]   = can_acc;
    end

    assign I_READY = !RST && tgt_ok && lane_rdy[tgt];
    assign accept  = I_VALID && I_READY;

    // Round-robin never skips a stalled lane, so word order across lanes is preserved.
    always_comb begin
        ptr_d = ptr_q;
        if ((MODE_RR != MODE_SEL) && accept) begin
            ptr_d = (ptr_q == SW'(N_OUT-1)) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign PTR = ptr_q;

    for (genvar k = 0; k < N_OUT; k++) begin : g_lane
        assign wr_en[k] = accept && (tgt == SW'(k));

        demux_lane_slot #(.W(W)) u_slot (
            .CLK        (CLK),
            .RST        (RST),
            .wr_en      (wr_en[k]),
            .wr_data    (I),
            .rd_ready   (O_READY[k]),
            .valid      (O_VALID[k]),
            .data       (O[k*W +: W]),
            .can_accept (can_acc[k])
        );
    end

endmodule

// File: tb/tb_demux_lane_buf.sv
// tb/tb_demux_lane_buf.sv - scoreboard bench for demux_lane_buf in select and round-robin modes
module tb_demux_lane_buf;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]  i2;  logic iv2, ir2;  logic [0:0] s2;  logic [15:0] o2;
    logic [1:0]  ov2, or2;  logic [0:0] ptr2;
    logic [7:0]  i3r; logic iv3r, ir3r; logic [1:0] s3r; logic [23:0] o3r;
    logic [2:0]  ov3r, or3r; logic [1:0] ptr3r;
    logic [7:0]  i3s; logic iv3s, ir3s; logic [1:0] s3s; logic [23:0] o3s;
    logic [2:0]  ov3s, or3s; logic [1:0] ptr3s;

    demux_lane_buf #(.N_OUT(2), .W(8), .MODE_RR(0)) u2 (
        .CLK(clk), .RST(rst), .I(i2), .I_VALID(iv2), .I_READY(ir2), .S(s2),
        .O(o2), .O_VALID(ov2), .O_READY(or2), .PTR(ptr2));
    demux_lane_buf #(.N_OUT(3), .W(8), .MODE_RR(1)) u3r (
        .CLK(clk), .RST(rst), .I(i3r), .I_VALID(iv3r), .I_READY(ir3r), .S(s3r),
        .O(o3r), .O_VALID(ov3r), .O_READY(or3r), .PTR(ptr3r));
    demux_lane_buf #(.N_OUT(3), .W(8), .MODE_RR(0)) u3s (
        .CLK(clk), .RST(rst), .I(i3s), .I_VALID(iv3s), .I_READY(ir3s), .S(s3s),
        .O(o3s), .O_VALID(ov3s), .O_READY(or3s), .PTR(ptr3s));

    int vecs = 0;
    int errs = 0;
    logic [7:0] q2 [2][$];
    logic [7:0] q3 [3][$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    // Drive one u2 word, check I_READY mid-cycle, push expectation if it should be taken.
    task automatic send2(input logic [7:0] d, input logic [0:0] s, input logic exp_rdy, input string nm);
        i2 = d; s2 = s; iv2 = 1'b1;
        @(negedge clk);
        chk(nm, 32'(ir2), 32'(exp_rdy));
        if (exp_rdy) q2[s].push_back(d);
        nxt();
    endtask

    task automatic send3r(input logic [7:0] d, input logic [1:0] exp_ptr, input string nm);
        i3r = d; s3r = 2'(d); iv3r = 1'b1;
        @(negedge clk);
        chk({nm, "_ptr"}, 32'(ptr3r), 32'(exp_ptr));
        chk({nm, "_rdy"}, 32'(ir3r), 32'(1));
        q3[exp_ptr].push_back(d);
        nxt();
    endtask

    // Monitor: every lane handshake must deliver the next expected word for that lane.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                if (ov2[k] && or2[k]) begin
                    if (q2[k].size() == 0) begin
                        vecs++; errs++;
                        $display("FAIL u2_unexpected lane=%0d actual=%0h required=none", k, o2[k*8 +: 8]);
                    end else begin
                        chk($sformatf("u2_lane%0d_data", k), 32'(o2[k*8 +: 8]), 32'(q2[k].pop_front()));
                    end
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (ov3r[k] && or3r[k]) begin
                    if (q3[k].size() == 0) begin
                        vecs++; errs++;
                        $display("FAIL u3r_unexpected lane=%0d actual=%0h required=none", k, o3r[k*8 +: 8]);
                    end else begin
                        chk($sformatf("u3r_lane%0d_data", k), 32'(o3r[k*8 +: 8]), 32'(q3[k].pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        i2 = 8'h00; iv2 = 1'b1; s2 = 1'b0; or2 = 2'b00;
        i3r = 8'h00; iv3r = 1'b1; s3r = 2'd0; or3r = 3'b000;
        i3s = 8'h00; iv3s = 1'b1; s3s = 2'd0; or3s = 3'b000;

        // Reset holds I_READY low even with I_VALID asserted.
        nxt(); nxt();
        @(negedge clk);
        chk("rst_ir2", 32'(ir2), 32'(0));
        chk("rst_ir3r", 32'(ir3r), 32'(0));
        chk("rst_ir3s", 32'(ir3s), 32'(0));
        nxt();
        rst = 1'b0; iv2 = 1'b0; iv3r = 1'b0; iv3s = 1'b0;
        @(negedge clk);
        chk("rst_ov2", 32'(ov2), 32'(0));
        chk("rst_o2", 32'(o2), 32'(0));
        chk("rst_ptr2", 32'(ptr2), 32'(0));
        chk("rst_ptr3r", 32'(ptr3r), 32'(0));
        chk("rst_ov3r", 32'(ov3r), 32'(0));
        nxt();

        // Select mode, no consumer ready.
        send2(8'hA5, 1'b1, 1'b1, "t2_a5_rdy");
        iv2 = 1'b0;
        @(negedge clk);
        chk("t2_ov_10", 32'(ov2), 32'(2'b10));
        chk("t2_o_hi", 32'(o2[15:8]), 32'(8'hA5));
        nxt();
        send2(8'h5A, 1'b1, 1'b0, "t2_full_lane1");
        send2(8'h3C, 1'b0, 1'b1, "t2_3c_rdy");
        iv2 = 1'b0;
        @(negedge clk);
        chk("t2_ov_11", 32'(ov2), 32'(2'b11));
        chk("t2_o_lo", 32'(o2[7:0]), 32'(8'h3C));
        chk("t2_o_hi_kept", 32'(o2[15:8]), 32'(8'hA5));
        nxt();

        // Back-to-back into lane 0 with all consumers ready.
        or2 = 2'b11;
        for (int d = 1; d <= 4; d++) send2(8'(d), 1'b0, 1'b1, $sformatf("t3_word%0d_rdy", d));
        iv2 = 1'b0;
        nxt();
        @(negedge clk);
        chk("t3_ov_empty", 32'(ov2), 32'(0));
        chk("t3_o_hold", 32'(o2[7:0]), 32'(8'h04));
        nxt();

        // Round-robin over three lanes.
        or3r = 3'b111;
        for (int n = 0; n < 6; n++) send3r(8'(10 + n), 2'(n % 3), $sformatf("t4_w%0d", 10 + n));
        iv3r = 1'b0;
        nxt();
        or3r = 3'b101;
        send3r(8'd20, 2'd0, "t4_w20");
        send3r(8'd21, 2'd1, "t4_w21");
        send3r(8'd22, 2'd2, "t4_w22");
        send3r(8'd23, 2'd0, "t4_w23");
        i3r = 8'd24; iv3r = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("t4_stall_rdy%0d", c), 32'(ir3r), 32'(0));
            chk($sformatf("t4_stall_ptr%0d", c), 32'(ptr3r), 32'(1));
            nxt();
        end
        or3r = 3'b111;
        @(negedge clk);
        chk("t4_release_rdy", 32'(ir3r), 32'(1));
        q3[1].push_back(8'd24);
        nxt();
        iv3r = 1'b0;
        @(negedge clk);
        chk("t4_ptr_after", 32'(ptr3r), 32'(2));
        nxt(); nxt();

        // Out-of-range select on a 3-lane block.
        i3s = 8'h77; s3s = 2'd2; iv3s = 1'b1;
        nxt();
        i3s = 8'hEE; s3s = 2'd3;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("t5_rdy%0d", c), 32'(ir3s), 32'(0));
            chk($sformatf("t5_ov%0d", c), 32'(ov3s), 32'(3'b100));
            chk($sformatf("t5_o%0d", c), 32'(o3s[23:16]), 32'(8'h77));
            chk($sformatf("t5_ptr%0d", c), 32'(ptr3s), 32'(0));
            nxt();
        end
        iv3s = 1'b0;

        // Reset in the middle of traffic.
        or2 = 2'b00;
        send2(8'h11, 1'b0, 1'b1, "t6_fill0");
        send2(8'h22, 1'b1, 1'b1, "t6_fill1");
        iv2 = 1'b0;
        @(negedge clk);
        chk("t6_full", 32'(ov2), 32'(2'b11));
        nxt();
        rst = 1'b1; i2 = 8'h33; s2 = 1'b0; iv2 = 1'b1;
        q2[0].delete(); q2[1].delete();
        for (int k = 0; k < 3; k++) q3[k].delete();
        @(negedge clk);
        chk("t6_rst_rdy", 32'(ir2), 32'(0));
        nxt();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_ov_clr", 32'(ov2), 32'(0));
        chk("t6_ptr3r_clr", 32'(ptr3r), 32'(0));
        chk("t6_ov3s_clr", 32'(ov3s), 32'(0));
        chk("t6_resume_rdy", 32'(ir2), 32'(1));
        q2[0].push_back(8'h33);
        nxt();
        iv2 = 1'b0;
        @(negedge clk);
        chk("t6_resume_ov", 32'(ov2), 32'(2'b01));
        chk("t6_resume_o", 32'(o2[7:0]), 32'(8'h33));
        nxt();
        or2 = 2'b11;
        nxt(); nxt();

        for (int k = 0; k < 2; k++) chk($sformatf("end_q2_lane%0d", k), 32'(q2[k].size()), 32'(0));
        for (int k = 0; k < 3; k++) chk($sformatf("end_q3_lane%0d", k), 32'(q3[k].size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
